// File: rtl/sram_fault_logger.sv
// Failure log for the SRAM pattern test. It stores up to DEPTH failing compares, keeps a saturating
// error count and sticky flags, and steps a registered readout through the logged entries.
module sram_fault_logger #(
  parameter int DEPTH = 8,
  parameter int AW    = 18,
  parameter int DW    = 16,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     sample,
  input  logic                     mismatch,
  input  logic [AW-1:0]            addr,
  input  logic [DW-1:0]            expected,
  input  logic [DW-1:0]            actual,
  input  logic                     next,
  output logic [AW-1:0]            rd_addr,
  output logic [DW-1:0]            rd_expected,
  output logic [DW-1:0]            rd_actual,
  output logic [$clog2(DEPTH)-1:0] rd_index,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   entries,
  output logic [CW-1:0]            err_count,
  output logic                     overflow,
  output logic                     first_fail
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] depth_full = (IW+1)'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] expected;
    logic [DW-1:0] actual;
  } entry_t;

  entry_t        log_mem [DEPTH];
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] rd_ptr;
  logic          next_q;
  logic          qualified;
  logic          full;
  logic          advance;
  logic [IW:0]   rd_ptr_inc;

  assign qualified  = sample && mismatch;
  assign full       = (entries == depth_full);
  assign advance    = next && !next_q;
  assign rd_ptr_inc = {1'b0, rd_ptr} + 1'b1;

  // NOTE: the log RAM has no reset so it maps onto plain memory; rd_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (!clr && qualified && !full)
      log_mem[wr_ptr] <= {addr, expected, actual};
  end

  // NOTE: all state here uses <= so every read sees the pre-edge value (wrap test uses old entries).
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      next_q      <= 1'b0;
      entries     <= '0;
      err_count   <= '0;
      overflow    <= 1'b0;
      first_fail  <= 1'b0;
      rd_addr     <= '0;
      rd_expected <= '0;
      rd_actual   <= '0;
      rd_index    <= '0;
      rd_valid    <= 1'b0;
    end else begin
      next_q <= next;

      if (qualified) begin
        first_fail <= 1'b1;
        if (err_count != '1)
          err_count <= err_count + 1'b1;
        if (full) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr  <= wr_ptr + 1'b1;
          entries <= entries + 1'b1;
        end
      end

      // Wrap over valid entries only; an empty log pins the pointer at 0.
      if (advance && entries != '0)
        rd_ptr <= (rd_ptr_inc == entries) ? '0 : rd_ptr_inc[IW-1:0];

      rd_addr     <= log_mem[rd_ptr].addr;
      rd_expected <= log_mem[rd_ptr].expected;
      rd_actual   <= log_mem[rd_ptr].actual;
      rd_index    <= rd_ptr;
      rd_valid    <= ({1'b0, rd_ptr} < entries);
    end
  end

endmodule

// File: tb/tb_sram_fault_logger.sv
// Randomized bench for sram_fault_logger: a queue-based model of the failure log is compared to
// the DUT every cycle, with directed scenarios pinning literal values.
module tb_sram_fault_logger;

  localparam int DEPTH = 8;
  localparam int AW    = 18;
  localparam int DW    = 16;
  localparam int CW    = 4;
  localparam int IW    = $clog2(DEPTH);
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr, sample, mismatch, next;
  logic [AW-1:0] addr;
  logic [DW-1:0] expected, actual;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_expected, rd_actual;
  logic [IW-1:0] rd_index;
  logic          rd_valid;
  logic [IW:0]   entries;
  logic [CW-1:0] err_count;
  logic          overflow, first_fail;

  sram_fault_logger #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .clr(clr), .sample(sample), .mismatch(mismatch),
    .addr(addr), .expected(expected), .actual(actual), .next(next),
    .rd_addr(rd_addr), .rd_expected(rd_expected), .rd_actual(rd_actual),
    .rd_index(rd_index), .rd_valid(rd_valid), .entries(entries),
    .err_count(err_count), .overflow(overflow), .first_fail(first_fail)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the log is a queue of captured failures, readout is an index into it.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    logic [DW-1:0] x;
  } ent_t;

  ent_t log_q[$];
  int   m_cnt, m_rd;
  bit   m_ovf, m_ff, m_nq;
  bit   d_valid, d_zero;
  int   d_idx;
  ent_t d_ent;
  bit   chk_en = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      log_q.delete();
      m_cnt = 0; m_rd = 0; m_ovf = 0; m_ff = 0; m_nq = 0;
      d_valid = 0; d_zero = 1; d_idx = 0;
    end else begin
      d_zero  = 0;
      d_valid = (m_rd < log_q.size());
      d_idx   = m_rd;
      if (d_valid) d_ent = log_q[m_rd];
      if (next && !m_nq && log_q.size() > 0) m_rd = (m_rd + 1) % log_q.size();
      if (sample && mismatch) begin
        m_ff = 1;
        if (m_cnt < CMAX) m_cnt++;
        if (log_q.size() < DEPTH) log_q.push_back('{addr, expected, actual});
        else m_ovf = 1;
      end
      m_nq = next;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("entries", 64'(entries), 64'(log_q.size()));
      check("err_count", 64'(err_count), 64'(m_cnt));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("first_fail", 64'(first_fail), 64'(m_ff));
      check("rd_valid", 64'(rd_valid), 64'(d_valid));
      check("rd_index", 64'(rd_index), 64'(d_idx));
      if (d_valid) begin
        check("rd_addr", 64'(rd_addr), 64'(d_ent.a));
        check("rd_expected", 64'(rd_expected), 64'(d_ent.e));
        check("rd_actual", 64'(rd_actual), 64'(d_ent.x));
      end else if (d_zero) begin
        check("rd_addr_rst", 64'(rd_addr), 64'h0);
        check("rd_expected_rst", 64'(rd_expected), 64'h0);
        check("rd_actual_rst", 64'(rd_actual), 64'h0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic randomize_data();
    addr     = AW'($urandom);
    expected = DW'($urandom);
    actual   = DW'($urandom);
  endtask

  task automatic do_clr();
    clr = 1'b1; sample = 1'b0; mismatch = 1'b0; next = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic fail_at(logic [AW-1:0] a);
    sample = 1'b1; mismatch = 1'b1;
    randomize_data();
    addr = a;
    tick();
  endtask

  task automatic pulse_next();
    next = 1'b1; tick();
    next = 1'b0; tick();
  endtask

  initial begin
    int exp_idx [4] = '{1, 2, 0, 1};

    // Reset with random inputs on the bus
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample = 1'($urandom); mismatch = 1'($urandom); next = 1'($urandom);
      randomize_data();
      tick();
    end
    chk_en = 1'b1;
    clr = 1'b0; sample = 1'b0; mismatch = 1'b0; next = 1'b0;
    check("rst_entries", 64'(entries), 64'h0);
    check("rst_err_count", 64'(err_count), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    check("rst_first_fail", 64'(first_fail), 64'h0);
    check("rst_rd_addr", 64'(rd_addr), 64'h0);
    pulse_next();
    tick();
    check("rst_next_index", 64'(rd_index), 64'h0);
    check("rst_next_valid", 64'(rd_valid), 64'h0);

    // Single failure
    sample = 1'b1; mismatch = 1'b1;
    addr = 18'h00123; expected = 16'hA5A5; actual = 16'hA5A4;
    tick();
    sample = 1'b0; mismatch = 1'b0;
    check("single_entries", 64'(entries), 64'd1);
    check("single_err_count", 64'(err_count), 64'd1);
    check("single_first_fail", 64'(first_fail), 64'd1);
    tick();
    check("single_rd_addr", 64'(rd_addr), 64'h00123);
    check("single_rd_actual", 64'(rd_actual), 64'hA5A4);
    check("single_rd_valid", 64'(rd_valid), 64'd1);

    // Passes and unqualified mismatches are ignored
    do_clr();
    for (int i = 0; i < 100; i++) begin
      sample = 1'b1; mismatch = 1'b0; randomize_data(); tick();
    end
    for (int i = 0; i < 20; i++) begin
      sample = 1'b0; mismatch = 1'b1; randomize_data(); tick();
    end
    mismatch = 1'b0;
    check("pass_entries", 64'(entries), 64'd0);
    check("pass_err_count", 64'(err_count), 64'd0);

    // Fill and overflow
    do_clr();
    for (int i = 0; i < 10; i++) fail_at(AW'(i));
    sample = 1'b0; mismatch = 1'b0;
    check("fill_entries", 64'(entries), 64'd8);
    check("fill_err_count", 64'(err_count), 64'd10);
    check("fill_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      pulse_next();
      check("fill_step_addr", 64'(rd_addr), 64'((i + 1) % 8));
    end

    // Readout wrap over three entries, then a long hold
    do_clr();
    for (int i = 0; i < 3; i++) fail_at(AW'(16'h100 + i));
    sample = 1'b0; mismatch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse_next();
      check("wrap_index", 64'(rd_index), 64'(exp_idx[i]));
    end
    next = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("hold_index", 64'(rd_index), 64'd2);
    next = 1'b0;
    tick();

    // Saturation, then clr coinciding with a failure
    do_clr();
    for (int i = 0; i < 20; i++) fail_at(AW'($urandom));
    check("sat_err_count", 64'(err_count), 64'(CMAX));
    clr = 1'b1; sample = 1'b1; mismatch = 1'b1;
    tick();
    clr = 1'b0; sample = 1'b0; mismatch = 1'b0;
    check("clr_cap_entries", 64'(entries), 64'd0);
    check("clr_cap_err_count", 64'(err_count), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      clr      = ($urandom_range(0, 99) == 0);
      sample   = 1'($urandom);
      mismatch = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) next = ~next;
      randomize_data();
      tick();
    end
    clr = 1'b0; sample = 1'b0; next = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_fault_logger.md
# sram_fault_logger

Downstream stage of the SRAM pattern test: consumes each read-back comparison (address, expected word, actual word, mismatch flag) and records up to DEPTH failing accesses in an internal log. It also keeps a saturating total-error count and a sticky overflow flag. A debounced button steps through logged entries for the 7-segment displays, so failures remain inspectable after the live compare has moved on.

## Interface

Parameters:
- DEPTH, 8, log entries; power of two, 2..64
- AW, 18, SRAM address width
- DW, 16, data word width
- CW, 16, error counter width

Ports:
- clk  in  1  system clock (fclk domain)
- clr  in  1  reset; synchronous, active-high
- sample  in  1  compare strobe; one cycle per read-back word
- mismatch  in  1  1 = actual differs from expected; qualified by sample
- addr  in  AW  address of the sampled access
- expected  in  DW  pattern word written
- actual  in  DW  word read back
- next  in  1  debounced step button (level); advance on rising edge
- rd_addr  out  AW  address of the displayed entry
- rd_expected  out  DW  expected word of the displayed entry
- rd_actual  out  DW  actual word of the displayed entry
- rd_index  out  log2(DEPTH)  index of the displayed entry
- rd_valid  out  1  displayed entry holds a logged failure
- entries  out  log2(DEPTH)+1  number of valid entries, 0..DEPTH
- err_count  out  CW  total mismatches seen, saturating
- overflow  out  1  sticky: a mismatch arrived while the log was full
- first_fail  out  1  sticky: at least one mismatch seen

## Operation

- Capture: on a clk edge with sample=1, mismatch=1 and entries<DEPTH, write {addr, expected, actual} to log[wr_ptr]. Increment wr_ptr and entries on the same edge.
- Full: with sample=1, mismatch=1 and entries==DEPTH, do not write; set overflow. Never overwrite existing entries.
- sample=1, mismatch=0: no log change and no count change. sample=0: mismatch and data are ignored.
- err_count: +1 per qualified mismatch, including while full. Saturates at 2^CW-1 and holds there with no wrap.
- first_fail: set on the first qualified mismatch; sticky.
- Readout pointer rd_ptr, with edge detect next_q <= next:
  - Advance when next=1 and next_q=0.
  - If entries==0, rd_ptr stays 0.
  - Otherwise rd_ptr <= (rd_ptr+1 == entries) ? 0 : rd_ptr+1, wrapping over valid entries only.
- Simultaneous capture and advance on the same edge: both take effect. The wrap test uses entries before the edge.
- Read path: rd_addr/rd_expected/rd_actual/rd_index are registered copies of log[rd_ptr] and rd_ptr, refreshed every edge. rd_valid <= (rd_ptr < entries).
- The log holds state until clr. There is no separate log clear.
- clr mid-capture or mid-readout: every pointer, count and flag returns to reset on that edge, and any concurrent capture is discarded. Log RAM contents are don't-care after reset, and rd_valid=0 masks them.

## Timing

- Reset values, one edge after clr=1:
  - rd_addr=0, rd_expected=0, rd_actual=0, rd_index=0, rd_valid=0
  - entries=0, err_count=0, overflow=0, first_fail=0
  - internal: wr_ptr=0, rd_ptr=0, next_q=0
- Capture latency: a mismatch sampled at edge N updates entries, err_count, first_fail and overflow as outputs after edge N.
- Readout latency: rd_* reflect a write or pointer change one edge later (N+1). No write-through bypass.
- next held high produces exactly one advance. A further advance needs next low for at least one cycle, then high again.
- next held high across clr release: next_q=0 after reset, so one advance occurs. With entries=0 it has no effect.
- sample may be asserted every cycle; the block accepts back-to-back captures with no stall.

## Test plan

- Reset: assert clr 2 cycles with random inputs. All outputs are 0 afterwards. Pulsing next leaves rd_index=0 and rd_valid=0.
- Single failure: sample+mismatch with addr=0x00123, expected=0xA5A5, actual=0xA5A4.
  - After that edge: entries=1, err_count=1, first_fail=1.
  - One edge later: rd_addr=0x00123, rd_actual=0xA5A4, rd_valid=1.
- Passes ignored: 100 samples with mismatch=0, plus mismatch=1 with sample=0. entries=0, err_count=0.
- Fill and overflow, DEPTH=8: 10 back-to-back failures at addr 0..9.
  - entries=8, err_count=10, overflow=1.
  - Stepping next 8 times shows rd_addr 1..7 then 0; addr 8 and 9 never appear.
- Readout wrap with 3 entries: 4 next pulses give rd_index 1, 2, 0, 1. next held high 20 cycles advances once.
- Saturation and mid-run reset, with CW=4:
  - 20 failures leave err_count=15.
  - clr asserted on the same edge as a failure sample gives entries=0 and err_count=0.
